// File: rtl/sawtooth_led_if.sv
// Bus between the sawtooth counter FSM and the LED driver: window bounds,
// live count and run flag in, LED bank and wrap pulse out.
interface sawtooth_led_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] N1_data_i;
  logic [DATA_W-1:0] N2_data_i;
  logic [DATA_W-1:0] sawtooth_cntr_i;
  logic              run_i;
  logic [17:0]       led_out;
  logic              wrap_o;

  modport master (
    output N1_data_i, N2_data_i, sawtooth_cntr_i, run_i,
    input  led_out, wrap_o
  );

  modport slave (
    input  N1_data_i, N2_data_i, sawtooth_cntr_i, run_i,
    output led_out, wrap_o
  );
endinterface

// File: rtl/sawtooth_led_driver.sv
// Sawtooth LED driver: turns the counter's position inside [N1,N2] into a
// 16-LED bar graph with a 12-step restoring divider (fixed 14-cycle period),
// and flashes an indicator LED for FLASH_CYCLES after each wrap-around.
module sawtooth_led_driver #(
  parameter int DATA_W       = 8,
  parameter int FLASH_CYCLES = 25_000_000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sawtooth_led_if.slave bus
);
  localparam int DVD_W = DATA_W + 4;
  localparam int IT_W  = $clog2(DVD_W);
  localparam int FL_W  = $clog2(FLASH_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIV    = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_span;
  logic              r_ge_lo;
  logic [DVD_W-1:0]  r_dvd;
  logic [DATA_W:0]   r_rem;
  logic [4:0]        r_quo;
  logic [IT_W-1:0]   r_iter;
  logic [DATA_W-1:0] r_prev;
  logic [15:0]       r_bar;
  logic              r_wrap;
  logic [FL_W-1:0]   r_flash;
  logic              r_run;

  logic [DATA_W-1:0] w_cnt, w_lo, w_hi, w_span, w_pos;
  logic              w_wrap;
  logic [DATA_W+1:0] w_trial;
  logic              w_fit;
  logic [4:0]        w_q;
  logic [15:0]       w_bar;

  // Capture-side window math, only consumed in IDLE
  assign w_cnt  = bus.sawtooth_cntr_i;
  assign w_lo   = (bus.N1_data_i < bus.N2_data_i) ? bus.N1_data_i : bus.N2_data_i;
  assign w_hi   = (bus.N1_data_i < bus.N2_data_i) ? bus.N2_data_i : bus.N1_data_i;
  assign w_span = w_hi - w_lo;
  assign w_pos  = (w_cnt < w_lo) ? '0 :
                  (w_cnt > w_hi) ? w_span : (w_cnt - w_lo);
  assign w_wrap = bus.run_i && (w_cnt < r_prev);

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign w_trial = {r_rem, r_dvd[DVD_W-1]};
  assign w_fit   = (w_trial >= {2'b00, r_span});

  // pos <= span keeps the quotient within 0..16, so 5 bits hold it all;
  // a zero span makes the divider meaningless and is decided by cnt >= lo
  assign w_q   = (r_span == '0) ? (r_ge_lo ? 5'd16 : 5'd0) : r_quo;
  assign w_bar = 16'((17'd1 << w_q) - 17'd1);

  assign bus.led_out = {r_run, (r_flash != '0), r_bar};
  assign bus.wrap_o  = r_wrap;

  // Capture / divide / update loop, fixed 14-cycle period
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_span  <= '0;
      r_ge_lo <= 1'b0;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_iter  <= '0;
      r_prev  <= '0;
      r_bar   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_span  <= w_span;
          r_ge_lo <= (w_cnt >= w_lo);
          r_dvd   <= {w_pos, 4'b0000};
          r_rem   <= '0;
          r_quo   <= '0;
          r_iter  <= '0;
          r_prev  <= w_cnt;
          r_state <= S_DIV;
        end
        S_DIV: begin
          // When the trial does not fit it is below span, so truncation is lossless
          r_rem  <= w_fit ? (DATA_W+1)'(w_trial - {2'b00, r_span})
                          : (DATA_W+1)'(w_trial);
          r_dvd  <= r_dvd << 1;
          r_quo  <= {r_quo[3:0], w_fit};
          r_iter <= r_iter + 1'b1;
          if (r_iter == IT_W'(DVD_W - 1)) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_bar   <= w_bar;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Wrap pulse and flash timer, both triggered by a wrap seen at capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wrap  <= 1'b0;
      r_flash <= '0;
    end else begin
      r_wrap <= (r_state == S_IDLE) && w_wrap;
      if ((r_state == S_IDLE) && w_wrap) r_flash <= FL_W'(FLASH_CYCLES);
      else if (r_flash != '0)            r_flash <= r_flash - 1'b1;
    end
  end

  // Run indicator, one-cycle registered copy of run_i
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_run <= 1'b0;
    else        r_run <= bus.run_i;
  end
endmodule

// File: tb/tb_sawtooth_led_driver.sv
// Bench for sawtooth_led_driver: directed window cases, randomized windows,
// wrap/flash timing and asynchronous reset mid-conversion, all compared to
// a plain-arithmetic reference model.
module tb_sawtooth_led_driver;
  localparam int FLASH = 20;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_chk = 0, n_pass = 0, n_fail = 0;
  int   ecnt;
  int   fl_total = 0;
  int   m_prev = 0;

  sawtooth_led_if #(.DATA_W(8)) bus ();

  sawtooth_led_driver #(.DATA_W(8), .FLASH_CYCLES(FLASH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Edges since reset release; captures happen on edges 1, 15, 29, ...
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // Number of cycles the flash LED was observed lit
  always @(negedge clk_i) begin
    if (bus.led_out[16]) fl_total <= fl_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bar level straight from the window definition
  function automatic logic [15:0] exp_bar(input int n1, input int n2, input int c);
    int lo, hi, span, pos, q;
    lo   = (n1 < n2) ? n1 : n2;
    hi   = (n1 < n2) ? n2 : n1;
    span = hi - lo;
    if (span == 0) q = (c >= lo) ? 16 : 0;
    else begin
      pos = (c < lo) ? 0 : (c > hi) ? span : c - lo;
      q   = (pos * 16) / span;
    end
    return 16'((32'd1 << q) - 1);
  endfunction

  // Park on the low phase just ahead of a capture edge
  task automatic wait_capture();
    while (!((ecnt % 14) == 0 && clk_i === 1'b0)) @(negedge clk_i);
  endtask

  task automatic do_conv(input int n1, input int n2, input int c, input logic run);
    logic [15:0] old_bar, e_bar;
    logic        e_wrap;
    wait_capture();
    bus.N1_data_i       = 8'(n1);
    bus.N2_data_i       = 8'(n2);
    bus.sawtooth_cntr_i = 8'(c);
    bus.run_i           = run;
    old_bar = bus.led_out[15:0];
    e_bar   = exp_bar(n1, n2, c);
    e_wrap  = run && (c < m_prev);
    m_prev  = c;
    @(posedge clk_i); #1;
    chk("wrap_pulse", 32'(bus.wrap_o), 32'(e_wrap));
    chk("run_led", 32'(bus.led_out[17]), 32'(run));
    // Inputs moving mid-conversion must not disturb the result
    bus.N1_data_i       = 8'($urandom);
    bus.N2_data_i       = 8'($urandom);
    bus.sawtooth_cntr_i = 8'($urandom);
    @(posedge clk_i); #1;
    chk("wrap_clear", 32'(bus.wrap_o), 32'd0);
    repeat (11) @(posedge clk_i);
    #1;
    chk("bar_hold", 32'(bus.led_out[15:0]), 32'(old_bar));
    @(posedge clk_i); #1;
    chk("bar", 32'(bus.led_out[15:0]), 32'(e_bar));
  endtask

  initial begin
    int s0;
    int n1, n2, c;
    logic r;

    // Reset with arbitrary inputs
    bus.N1_data_i       = 8'($urandom);
    bus.N2_data_i       = 8'($urandom);
    bus.sawtooth_cntr_i = 8'($urandom);
    bus.run_i           = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_led", 32'(bus.led_out), 32'd0);
    chk("reset_wrap", 32'(bus.wrap_o), 32'd0);
    @(negedge clk_i);
    rst_i  = 1'b1;
    m_prev = 0;

    // Directed window cases
    do_conv(10, 90, 50, 1'b1);
    do_conv(90, 10, 50, 1'b1);
    do_conv(10, 90, 5, 1'b1);
    do_conv(10, 90, 200, 1'b1);
    do_conv(10, 90, 90, 1'b1);
    do_conv(10, 90, 15, 1'b1);
    do_conv(20, 20, 20, 1'b1);
    do_conv(20, 20, 19, 1'b1);
    do_conv(0, 255, 128, 1'b0);

    // Randomized windows, some degenerate
    for (int i = 0; i < 12; i++) begin
      n1 = int'($urandom_range(0, 255));
      n2 = (i % 4 == 0) ? n1 : int'($urandom_range(0, 255));
      c  = int'($urandom_range(0, 255));
      r  = 1'($urandom_range(0, 1));
      do_conv(n1, n2, c, r);
    end

    // Single wrap: flash lit for exactly FLASH cycles
    do_conv(10, 90, 90, 1'b1);
    do_conv(10, 90, 90, 1'b1);
    s0 = fl_total;
    do_conv(10, 90, 10, 1'b1);
    do_conv(10, 90, 10, 1'b1);
    do_conv(10, 90, 10, 1'b1);
    chk("flash_len", 32'(fl_total - s0), 32'(FLASH));
    chk("flash_off", 32'(bus.led_out[16]), 32'd0);

    // Second wrap during the flash restarts the full duration
    do_conv(10, 90, 90, 1'b1);
    do_conv(10, 90, 90, 1'b1);
    s0 = fl_total;
    do_conv(10, 90, 10, 1'b1);
    do_conv(10, 90, 5, 1'b1);
    do_conv(10, 90, 5, 1'b1);
    do_conv(10, 90, 5, 1'b1);
    chk("flash_extend", 32'(fl_total - s0), 32'(14 + FLASH));
    chk("flash_off2", 32'(bus.led_out[16]), 32'd0);

    // Count drop while not running is not a wrap
    do_conv(10, 90, 90, 1'b1);
    s0 = fl_total;
    do_conv(10, 90, 10, 1'b0);
    chk("no_flash_idle", 32'(fl_total - s0), 32'd0);

    // Asynchronous reset during DIV iteration 6
    do_conv(10, 90, 50, 1'b1);
    wait_capture();
    bus.N1_data_i       = 8'd10;
    bus.N2_data_i       = 8'd90;
    bus.sawtooth_cntr_i = 8'd15;
    bus.run_i           = 1'b1;
    repeat (7) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("midreset_led", 32'(bus.led_out), 32'd0);
    chk("midreset_wrap", 32'(bus.wrap_o), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i  = 1'b1;
    m_prev = 0;
    do_conv(0, 255, 255, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
